// File: rtl/ringosc_pkg.sv
// ringosc_pkg: shared FSM state type and constant helpers for the ring-oscillator frequency meter.
//   state_t   : IDLE / ARM / GATE / DONE measurement states
//   sel_width : channel-select width, clog2(n) with a floor of 1
//   sat_max   : all-ones saturation value for a w-bit edge counter
package ringosc_pkg;
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [63:0] sat_max(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/ringosc_edge_sync.sv
// ringosc_edge_sync: SYNC_STAGES-deep synchroniser plus rising-edge detector for one oscillator tap.
//   clk, rst_n : system clock, asynchronous active-low reset
//   osc_i      : asynchronous (prescaled) oscillator tap
//   edge_o     : one-cycle pulse per synchronised rising edge
module ringosc_edge_sync
  import ringosc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_i,
  output logic edge_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], osc_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/ringosc_freq_meter.sv
// ringosc_freq_meter: counts rising edges of one selected oscillator tap over a gate window of clk cycles.
//   clk, rst_n       : system clock, asynchronous active-low reset
//   osc_i[NUM_OSC]   : prescaled oscillator taps (asynchronous)
//   sel_i/gate_i/cont_i : channel, gate length (clk cycles), continuous mode; sampled on accepted start
//   start_i, stop_i  : start measurement / abort to IDLE (stop has priority)
//   cnt_o, ovf_o     : last completed result and its saturation flag
//   valid_o          : one-cycle pulse when cnt_o updates
//   busy_o           : measurement in progress
//   min_o, max_o     : running min/max of results since last start (only with RINGOSC_MINMAX_EN)
module ringosc_freq_meter
  import ringosc_pkg::*;
#(
  parameter int NUM_OSC     = 4,
  parameter int SEL_W       = sel_width(NUM_OSC),
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_OSC-1:0] osc_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [GATE_W-1:0]  gate_i,
  input  logic               start_i,
  input  logic               cont_i,
  input  logic               stop_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               ovf_o
`ifdef RINGOSC_MINMAX_EN
  ,
  output logic [CNT_W-1:0]   min_o,
  output logic [CNT_W-1:0]   max_o
`endif
);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  // Unused select codes (NUM_OSC not a power of two) read a constant zero.
  logic [(1<<SEL_W)-1:0] edge_vec;
  for (genvar i = 0; i < (1 << SEL_W); i++) begin : g_tap
    if (i < NUM_OSC) begin : g_on
      ringosc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .osc_i (osc_i[i]),
        .edge_o(edge_vec[i])
      );
    end else begin : g_off
      assign edge_vec[i] = 1'b0;
    end
  end

  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [GATE_W-1:0] gate_q, gate_d, gcnt_q, gcnt_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [CNT_W-1:0] count_q, count_d, cnt_q, cnt_d, count_inc;
  logic cont_q, cont_d, flag_q, flag_d, ovf_q, ovf_d, valid_q, valid_d, busy_q, busy_d;
  logic edge_sel, sat_hit, flag_inc;

  assign edge_sel  = edge_vec[sel_q];
  assign sat_hit   = edge_sel && (count_q == CNT_MAX);
  assign count_inc = (edge_sel && !sat_hit) ? count_q + CNT_W'(1) : count_q;
  assign flag_inc  = flag_q | sat_hit;

  // Outputs are registered on the transition into DONE, so valid_o, cnt_o
  // and ovf_o all change together during the DONE cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gate_d  = gate_q;
    cont_d  = cont_q;
    arm_d   = arm_q;
    gcnt_d  = gcnt_q;
    count_d = count_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_d = ARM;
          sel_d   = sel_i;
          gate_d  = gate_i;
          cont_d  = cont_i;
          arm_d   = '0;
          count_d = '0;
          flag_d  = 1'b0;
        end
        // ARM spans SYNC_STAGES+1 cycles so stale synchroniser contents never count.
        ARM: if (arm_q == ARM_W'(SYNC_STAGES)) begin
          if (gate_q == '0) begin
            state_d = DONE;
            valid_d = 1'b1;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = GATE;
            gcnt_d  = gate_q;
          end
        end else begin
          arm_d = arm_q + ARM_W'(1);
        end
        GATE: begin
          count_d = count_inc;
          flag_d  = flag_inc;
          gcnt_d  = gcnt_q - GATE_W'(1);
          if (gcnt_q == GATE_W'(1)) begin
            state_d = DONE;
            valid_d = 1'b1;
            cnt_d   = count_inc;
            ovf_d   = flag_inc;
          end
        end
        // Continuing windows start counting on the DONE cycle itself: no dead time.
        DONE: if (!cont_q) begin
          state_d = IDLE;
        end else if (gate_q == '0) begin
          valid_d = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = GATE;
          gcnt_d  = gate_q;
          count_d = edge_sel ? CNT_W'(1) : '0;
          flag_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == ARM) || (state_d == GATE) || ((state_d == DONE) && cont_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gate_q  <= '0;
      cont_q  <= 1'b0;
      arm_q   <= '0;
      gcnt_q  <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gate_q  <= gate_d;
      cont_q  <= cont_d;
      arm_q   <= arm_d;
      gcnt_q  <= gcnt_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

`ifdef RINGOSC_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
  logic start_ok;
  assign start_ok = (state_q == IDLE) && start_i && !stop_i;
  always_comb begin
    min_d = start_ok ? '1 : (valid_d && cnt_d < min_q) ? cnt_d : min_q;
    max_d = start_ok ? '0 : (valid_d && cnt_d > max_q) ? cnt_d : max_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
  assign min_o = min_q;
  assign max_o = max_q;
`endif
endmodule

// File: doc/ringosc_freq_meter.md
Name: ringosc_freq_meter

Overview:
- Multi-channel, parametrised successor to the single ring-oscillator counter. Counts rising edges of one selected oscillator tap over a programmable gate window of `clk` cycles, then holds the result.
- Sits between the ring-oscillator macros, whose `osc_i` taps are already prescaled so that f_osc < f_clk/2, and the `uo_out`/register read-back logic.
- Supports single-shot and continuous modes, saturation, and abort.

Parameters:
- NUM_OSC, 4: number of oscillator taps (>=1).
- SEL_W, 2: width of `sel_i`, equal to clog2(NUM_OSC) with a minimum of 1.
- CNT_W, 16: edge-count and result width.
- GATE_W, 16: gate-window length width, in clk cycles.
- SYNC_STAGES, 2: synchroniser flops per tap (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- osc_i  in  NUM_OSC  prescaled ring-oscillator taps, asynchronous to clk.
- sel_i  in  SEL_W  channel select, sampled on start.
- gate_i  in  GATE_W  gate length in clk cycles, sampled on start.
- start_i  in  1  start pulse, level-sensitive per cycle.
- cont_i  in  1  continuous mode, sampled on start.
- stop_i  in  1  abort; returns to IDLE.
- cnt_o  out  CNT_W  last completed result.
- valid_o  out  1  one-cycle pulse when cnt_o updates.
- busy_o  out  1  high in ARM or GATE.
- ovf_o  out  1  last result saturated.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cnt_o=0, valid_o=0, busy_o=0, ovf_o=0; internal counters and synchronisers cleared. Reset may assert mid-measurement; the partial result is discarded.
- Each tap passes through SYNC_STAGES flops. A rising edge is detected as sync=1 while prev=0, on the selected channel only.
- State machine:
  - IDLE: on start_i=1 and stop_i=0, latch sel/gate/cont, clear edge counter, then go to ARM.
  - ARM: wait SYNC_STAGES+1 cycles to flush the synchroniser and edge detector; edges in this time are ignored. Then load the gate counter with the latched gate value and go to GATE. If the latched gate is 0, go straight to DONE with count 0.
  - GATE: lasts exactly gate cycles. Each cycle with a detected edge increments the counter. The counter saturates at 2^CNT_W-1 and sets a sticky ovf flag. After the last gate cycle, go to DONE.
  - DONE (1 cycle): cnt_o<=count, ovf_o<=flag, valid_o=1. If cont is latched, re-clear the counter and go to GATE directly (no ARM). Otherwise go to IDLE.
- Continuous mode has no dead time between windows: the edge on the DONE cycle is counted into the next window. sel/gate are not re-sampled; start_i is ignored while busy.
- stop_i has priority over every other input in any state. Next cycle: IDLE, busy_o=0, no valid_o. cnt_o/ovf_o keep their previous values.
- start_i and stop_i asserted together in IDLE: stay IDLE.
- busy_o=1 in ARM and GATE, and in DONE when continuing.
- Latency in single shot: start seen at cycle T gives valid_o at T+1+(SYNC_STAGES+1)+gate.

Optional Feature:
- Macro `RINGOSC_MINMAX_EN`.
- When defined: adds outputs min_o and max_o (each CNT_W wide). At each DONE, min_o<=min(min_o,result) and max_o<=max(max_o,result). Both are re-initialised on an accepted start_i to min=all-ones, max=0. Reset values are min_o=all-ones, max_o=0.
- When undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package ringosc_pkg: state enum (IDLE, ARM, GATE, DONE), a clog2-based SEL_W helper, and the count saturation constant function.
- One sub-module, ringosc_edge_sync: a per-tap SYNC_STAGES synchroniser plus rising-edge detector, instantiated NUM_OSC times. The top muxes the edge pulses with the latched sel.

Test Plan:
- Reset then idle: rst_n=0 mid-GATE, then release → cnt_o=0, valid_o=0, busy_o=0, no valid_o afterwards.
- Single shot: ch2 = 40 ns period, clk 10 ns, gate=100, start → valid_o at T+104 (SYNC_STAGES=2), cnt_o=25, ovf_o=0.
- Saturation: CNT_W=4, ch0 period 40 ns, gate=200 → cnt_o=15, ovf_o=1.
- Continuous: cont=1, gate=50, 40 ns tap → valid_o pulses every 51 cycles, each cnt_o in {12,13} and the sum across windows equals total edges. Then stop_i → busy_o=0 next cycle, cnt_o held.
- Edge cases:
  - gate=0 → valid_o at T+4, cnt_o=0.
  - start_i with stop_i in IDLE → no busy.
  - sel change during GATE → result unchanged.
- With `RINGOSC_MINMAX_EN`: continuous with the tap period switched 40 ns→80 ns between windows → min_o=6, max_o=12 for gate=50 (±1).
